// File: rtl/bw_frame_buffer_pkg.sv
// Shared defaults, derived widths and write-FSM encoding for the BW frame buffer.
package bw_frame_buffer_pkg;
  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int X_OFF_DEF = 256;
  localparam int Y_OFF_DEF = 176;
  localparam int ADDR_W_DEF = $clog2(IMG_W_DEF * IMG_H_DEF);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;
endpackage

// File: rtl/bw_frame_buffer_if.sv
// Pixel-stream in, VGA coordinates in, display pixel and status out.
interface bw_frame_buffer_if;
  logic       bite;
  logic       bite_valid;
  logic       vsync_start;
  logic [9:0] x;
  logic [9:0] y;
  logic       color_out;
  logic       frame_ready;
  logic       overflow;

  modport master (
    output bite, bite_valid, vsync_start, x, y,
    input  color_out, frame_ready, overflow
  );

  modport slave (
    input  bite, bite_valid, vsync_start, x, y,
    output color_out, frame_ready, overflow
  );
endinterface

// File: rtl/bw_dpram.sv
// 1-bit simple dual-port RAM: one write port, one registered read port.
module bw_dpram #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);
  logic mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/bw_frame_buffer.sv
// Double-buffered 1-bit frame store: fill one bank from the pixel stream while
// the other is scanned out to VGA; banks swap on vsync once a fill completes.
module bw_frame_buffer
  import bw_frame_buffer_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int X_OFF = X_OFF_DEF,
  parameter int Y_OFF = Y_OFF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  bw_frame_buffer_if.slave bus
);
  localparam int AW = $clog2(IMG_W * IMG_H);
  localparam int XW = $clog2(IMG_W);
  localparam int HW = AW - XW;
  localparam logic [10:0] X_LO = 11'(X_OFF);
  localparam logic [10:0] X_HI = 11'(X_OFF + IMG_W);
  localparam logic [10:0] Y_LO = 11'(Y_OFF);
  localparam logic [10:0] Y_HI = 11'(Y_OFF + IMG_H);

  wr_state_t       state;
  logic [XW-1:0]   wr_x;
  logic [HW-1:0]   wr_y;
  logic            wr_bank;
  logic            frame_ready_q;
  logic            overflow_q;
  logic            show_q;
  logic            rd_data;
  logic            we;
  logic            in_win;
  logic [9:0]      rx;
  logic [9:0]      ry;
  logic            unused_bits;

  // Bank bit is the RAM address MSB; display bank is always the other one.
  assign we     = (state == FILL) && bus.bite_valid;
  assign rx     = bus.x - 10'(X_OFF);
  assign ry     = bus.y - 10'(Y_OFF);
  assign in_win = ({1'b0, bus.x} >= X_LO) && ({1'b0, bus.x} < X_HI) &&
                  ({1'b0, bus.y} >= Y_LO) && ({1'b0, bus.y} < Y_HI);
  assign unused_bits = ^{rx[9:XW], ry[9:HW]};

  bw_dpram #(.AW(AW + 1)) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr ({wr_bank, wr_y, wr_x}),
    .wr_data (bus.bite),
    .rd_addr ({~wr_bank, ry[HW-1:0], rx[XW-1:0]}),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FILL;
      wr_x          <= '0;
      wr_y          <= '0;
      wr_bank       <= 1'b0;
      frame_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
      show_q        <= 1'b0;
    end else begin
      show_q <= in_win && frame_ready_q;
      case (state)
        // vsync is deliberately ignored here, even on the final write.
        FILL: if (bus.bite_valid) begin
          if (wr_x == XW'(IMG_W - 1)) begin
            wr_x <= '0;
            if (wr_y == HW'(IMG_H - 1)) begin
              wr_y  <= '0;
              state <= FULL;
            end else begin
              wr_y <= wr_y + 1'b1;
            end
          end else begin
            wr_x <= wr_x + 1'b1;
          end
        end
        FULL: begin
          if (bus.bite_valid) overflow_q <= 1'b1;
          if (bus.vsync_start) begin
            wr_bank       <= ~wr_bank;
            frame_ready_q <= 1'b1;
            state         <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // RAM read and window/ready gate are both one register deep.
  assign bus.color_out   = rd_data && show_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.overflow    = overflow_q;
endmodule
